// File: rtl/mem_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ram_pkg
// Description : Shared definitions for the RAM arbiter slice: default RAM
//               geometry, sequencer state encoding and the latched command
//               layout.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ram_pkg;

   // Default geometry of the 64x8 synchronous RAM
   localparam int C_ADDR_W = 6;
   localparam int C_DATA_W = 8;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Command as captured at grant time (default geometry)
   typedef struct packed {
      logic                we;
      logic [C_ADDR_W-1:0] addr;
      logic [C_DATA_W-1:0] wdata;
      logic                id;
   } cmd_t;

endpackage : mem_ram_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter. Grant is combinational from the
//               request vector and a 1-bit priority pointer; the pointer moves
//               to the non-granted side whenever a grant is taken (advance).
// Ports       : clk      - clock
//               rst      - asynchronous active-low reset (pointer -> 0)
//               req[1:0] - request vector
//               advance  - the current grant is consumed this cycle
//               grant    - one-hot grant (all zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   // Pointer names the side that wins a tie
   logic r_ptr;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   // After granting side 0 the tie goes to side 1, and vice versa
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= 1'b0;
      end else if (advance) begin
         r_ptr <= grant[0];
      end
   end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_ram_arbiter
// Description : Two-requester round-robin arbiter and sequencer in front of
//               the 64x8 synchronous RAM. One command is accepted in IDLE,
//               issued to the RAM for exactly one cycle (ACCESS) and answered
//               with a one-cycle response pulse (RESP).
// Ports       : req0_* / req1_*  - valid/ready command channels (we, addr, wdata)
//               rsp0_valid/rsp1_valid, rsp_rdata - response pulses + read data
//               busy             - sequencer not in IDLE
//               ram_*            - RAM control/data pins (sole driver)
//               clk, rst         - clock, asynchronous active-low reset
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ram_arbiter
   import mem_ram_pkg::*;
#(
   parameter int ADDR_W = C_ADDR_W,
   parameter int DATA_W = C_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp0_valid,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              ram_read_rq,
   output logic              ram_write_rq,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_write_data,
   input  logic [DATA_W-1:0] ram_read_data
);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_ACCESS = ST_ACCESS;
   localparam logic [1:0] S_RESP   = ST_RESP;

   logic [1:0]        r_state;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_id;
   logic [DATA_W-1:0] r_rdata;

   logic              w_idle;
   logic              w_access;
   logic              w_resp;
   logic [1:0]        w_req;
   logic [1:0]        w_grant;
   logic              w_advance;

   // Qualifying with rst keeps ready low while reset is held even if a
   // requester already presents valid.
   assign w_idle    = (r_state == S_IDLE) & rst;
   assign w_access  = (r_state == S_ACCESS);
   assign w_resp    = (r_state == S_RESP);
   assign w_req     = {req1_valid, req0_valid};
   assign w_advance = w_idle & (|w_req);

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (w_req),
      .advance (w_advance),
      .grant   (w_grant)
   );

   assign req0_ready = w_idle & w_grant[0];
   assign req1_ready = w_idle & w_grant[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_id    <= 1'b0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_advance) begin
                  r_we    <= w_grant[1] ? req1_we    : req0_we;
                  r_addr  <= w_grant[1] ? req1_addr  : req0_addr;
                  r_wdata <= w_grant[1] ? req1_wdata : req0_wdata;
                  r_id    <= w_grant[1];
                  r_state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               // Read data is the pre-write RAM content; writes leave it alone
               if (!r_we) begin
                  r_rdata <= ram_read_data;
               end
               r_state <= S_RESP;
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // RAM pins are only non-zero during the single ACCESS cycle
   assign ram_write_rq   = w_access & r_we;
   assign ram_read_rq    = w_access & ~r_we;
   assign ram_address    = w_access ? r_addr  : '0;
   assign ram_write_data = w_access ? r_wdata : '0;

   assign rsp0_valid = w_resp & ~r_id;
   assign rsp1_valid = w_resp & r_id;
   assign rsp_rdata  = r_rdata;
   assign busy       = (r_state != S_IDLE);

endmodule : mem_ram_arbiter
`default_nettype wire
